// File: rtl/reaction_timer_core.sv
// Reaction timer engine: start, random wait, stimulus, BCD ms capture.
// Optional false-start detection enabled by defining REACTION_FOUL_EN.
module reaction_timer_core #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_BITS   = 10
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       React,
  output logic       Stimulus,
  output logic       Busy,
  output logic       Foul,
  output logic       Compare,
  output logic [3:0] Digit3,
  output logic [3:0] Digit2,
  output logic [3:0] Digit1,
  output logic [3:0] Digit0
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS) + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ARMED,
`ifdef REACTION_FOUL_EN
    S_DONE,
    S_FOUL
`else
    S_DONE
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic             react_prev_q, react_prev_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             cmp_q, cmp_d;
  logic             start_edge;
  logic             react_edge;
  logic             tick;
  logic [15:0]      bcd_inc;
  logic             at_max;

`ifdef REACTION_FOUL_EN
  logic             foul_q, foul_d;
  assign Foul = foul_q;
`else
  assign Foul = 1'b0;
`endif

  assign start_edge = Start & ~start_prev_q;
  assign react_edge = React & ~react_prev_q;
  assign tick       = (div_q == DIV_LAST);
  assign at_max     = (bcd_q == 16'h9999);

  assign Stimulus = stim_q;
  assign Busy     = busy_q;
  assign Compare  = cmp_q;
  assign Digit3   = bcd_q[15:12];
  assign Digit2   = bcd_q[11:8];
  assign Digit1   = bcd_q[7:4];
  assign Digit0   = bcd_q[3:0];

  // Edge history and free-running LFSR (taps 16,14,13,11)
  always_comb begin
    start_prev_d = Start;
    react_prev_d = React;
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Four-digit BCD increment with rippling carries
  always_comb begin
    logic carry;
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Next-state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    bcd_d   = bcd_q;
    cmp_d   = 1'b0;
`ifdef REACTION_FOUL_EN
    foul_d  = foul_q;
`endif
    if (state_q == S_WAIT || state_q == S_ARMED) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end else begin
      div_d = '0;
    end

    unique case (state_q)
      S_WAIT: begin
`ifdef REACTION_FOUL_EN
        if (react_edge) begin
          state_d = S_FOUL;
          foul_d  = 1'b1;
        end else
`endif
        if (tick) begin
          if (dly_q <= DLY_W'(1)) begin
            state_d = S_ARMED;
            dly_d   = '0;
            div_d   = '0;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      S_ARMED: begin
        if (react_edge) begin
          state_d = S_DONE;
          cmp_d   = 1'b1;
          bcd_d   = (bcd_q == 16'h0000) ? 16'h0001 : bcd_q;
        end else if (tick) begin
          if (at_max) begin
            state_d = S_DONE;
          end else begin
            bcd_d = bcd_inc;
          end
        end
      end
      default: begin
        if (start_edge) begin
          state_d = S_WAIT;
          dly_d   = DLY_W'(MIN_DELAY_MS)
                  + DLY_W'(lfsr_q[DELAY_BITS-1:0]);
          bcd_d   = '0;
          div_d   = '0;
`ifdef REACTION_FOUL_EN
          foul_d  = 1'b0;
`endif
        end
      end
    endcase

    stim_d = (state_d == S_ARMED);
    busy_d = (state_d == S_WAIT) || (state_d == S_ARMED);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      react_prev_q <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      div_q        <= '0;
      dly_q        <= '0;
      bcd_q        <= '0;
      stim_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmp_q        <= 1'b0;
`ifdef REACTION_FOUL_EN
      foul_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      react_prev_q <= react_prev_d;
      lfsr_q       <= lfsr_d;
      div_q        <= div_d;
      dly_q        <= dly_d;
      bcd_q        <= bcd_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      cmp_q        <= cmp_d;
`ifdef REACTION_FOUL_EN
      foul_q       <= foul_d;
`endif
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed/random bench for reaction_timer_core.
// Small parameters: 4 cycles per ms, wait of 2..5 ms.
module tb_reaction_timer_core;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       react = 1'b0;
  logic       stim, busy, foul, cmp;
  logic [3:0] d3, d2, d1, d0;
  logic [15:0] m_lfsr;
  int total = 0;
  int bad = 0;

  reaction_timer_core #(
    .TICK_DIV(4),
    .MIN_DELAY_MS(2),
    .DELAY_BITS(2)
  ) dut (
    .Clock(clk),
    .Resetn(rstn),
    .Start(start),
    .React(react),
    .Stimulus(stim),
    .Busy(busy),
    .Foul(foul),
    .Compare(cmp),
    .Digit3(d3),
    .Digit2(d2),
    .Digit1(d1),
    .Digit0(d0)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seeded in reset, steps every clock otherwise
  always @(posedge clk) begin
    if (!rstn) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [15:0] bcd(input int n);
    bcd = {4'((n / 1000) % 10), 4'((n / 100) % 10),
           4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] digs();
    digs = {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start a run and wait for the stimulus; ends on the negedge
  // where Stimulus is first seen high.
  task automatic arm(input int react_at, output int d);
    int   c;
    logic busy_ok;
    logic cmp_seen;
    d = 2 + int'(m_lfsr[1:0]);
    start = 1'b1;
    c = 0;
    busy_ok = 1'b1;
    cmp_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        react = 1'b0;
        chk("wait_digits_clear", digs(), 16'h0000);
        chk("wait_foul_clear", foul, 1'b0);
      end
      if (i == react_at) react = 1'b1;
      if (i == react_at + 1) react = 1'b0;
      cmp_seen |= cmp;
      if (stim) begin
        c = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    react = 1'b0;
    chk("arm_latency", c, 4 * d + 1);
    chk("arm_busy", busy_ok, 1'b1);
    chk("arm_no_cmp", cmp_seen, 1'b0);
  endtask

  // React j cycles after stimulus seen; expect floor(j/4) ms, min 1
  task automatic measure(input int j);
    int ms;
    ms = j / 4;
    if (ms == 0) ms = 1;
    step(j);
    react = 1'b1;
    @(negedge clk);
    chk("meas_cmp", cmp, 1'b1);
    chk("meas_digits", digs(), bcd(ms));
    chk("meas_stim", stim, 1'b0);
    chk("meas_busy", busy, 1'b0);
    react = 1'b0;
    @(negedge clk);
    chk("meas_cmp_once", cmp, 1'b0);
    chk("meas_hold", digs(), bcd(ms));
  endtask

  initial begin
    int  d;
    int  j;
    logic seen;

    step(3);
    chk("rst_stim", stim, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_foul", foul, 1'b0);
    chk("rst_cmp", cmp, 1'b0);
    chk("rst_digits", digs(), 16'h0000);

    rstn = 1'b1;
    arm(0, d);
    chk("seed_delay", d, 2 + int'(16'hACE1 & 16'h3));
    measure(148 + int'($urandom_range(0, 3)));

    arm(0, d);
    measure(int'($urandom_range(0, 1)));

    for (int r = 0; r < 3; r++) begin
      arm(0, d);
      measure(int'($urandom_range(4, 400)));
    end

`ifdef REACTION_FOUL_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d = int'($urandom_range(1, 6));
    step(d);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk("foul_set", foul, 1'b1);
    chk("foul_busy", busy, 1'b0);
    chk("foul_stim", stim, 1'b0);
    chk("foul_cmp", cmp, 1'b0);
    chk("foul_digits", digs(), 16'h0000);
    step(3);
    chk("foul_hold", foul, 1'b1);
    arm(0, d);
    measure(int'($urandom_range(4, 100)));
`else
    step(2);
    d = 2 + int'(m_lfsr[1:0]);
    arm(int'($urandom_range(2, 4 * d - 1)), j);
    chk("wait_react_foul", foul, 1'b0);
    measure(int'($urandom_range(4, 100)));
`endif

    arm(0, d);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 100) start = 1'b1;
      if (k == 101) start = 1'b0;
    end
    chk("armed_start_ign", digs(), bcd(50));
    chk("armed_start_stim", stim, 1'b1);
    rstn = 1'b0;
    react = 1'b1;
    @(negedge clk);
    chk("mid_rst_stim", stim, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmp", cmp, 1'b0);
    chk("mid_rst_digits", digs(), 16'h0000);
    rstn = 1'b1;
    react = 1'b0;
    step(5);
    chk("idle_busy", busy, 1'b0);
    react = 1'b1;
    @(negedge clk);
    chk("idle_react_cmp", cmp, 1'b0);
    chk("idle_react_busy", busy, 1'b0);
    react = 1'b0;
    @(negedge clk);

    arm(0, d);
    seen = 1'b0;
    for (j = 1; j <= 40000; j++) begin
      @(negedge clk);
      seen |= cmp;
      if (j == 36) chk("carry_9", digs(), bcd(9));
      if (j == 40) chk("carry_10", digs(), bcd(10));
      if (j == 396) chk("carry_99", digs(), bcd(99));
      if (j == 400) chk("carry_100", digs(), bcd(100));
      if (j == 3996) chk("carry_999", digs(), bcd(999));
      if (j == 4000) chk("carry_1000", digs(), bcd(1000));
      if (j == 39999) chk("pre_to_stim", stim, 1'b1);
    end
    chk("to_digits", digs(), 16'h9999);
    chk("to_stim", stim, 1'b0);
    chk("to_busy", busy, 1'b0);
    chk("to_no_cmp", seen, 1'b0);
    react = 1'b1;
    @(negedge clk);
    chk("done_react_cmp", cmp, 1'b0);
    chk("done_react_digits", digs(), 16'h9999);
    react = 1'b0;
    @(negedge clk);

    react = 1'b1;
    arm(0, d);
    measure(int'($urandom_range(8, 60)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
